// File: rtl/id_stage.sv
// RV32I decode / operand-fetch stage: register file, immediate generation and a
// registered ID/EX output with valid/ready handshake, flush and writeback bypass.
module id_stage #(
    parameter int unsigned XLEN             = 32,  // only 32 is supported
    parameter bit          RESET_PC_INVALID = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic [6:0]      ex_opcode,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_we,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic [2:0]      ex_mem_funct3,
    output logic [XLEN-1:0] ex_store_data,
    output logic            ex_illegal
);

    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic [2:0]  mem_funct3;
        logic [31:0] store_data;
        logic        illegal;
    } ex_t;

    logic [31:0] rf_q [32];
    ex_t         ex_q, ex_d, dec;
    logic        ex_valid_q, ex_valid_d;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_u;
    logic [31:0] rs1_val, rs2_val;
    logic        is_shift, wb_hit, accept;

    assign opcode   = if_instr[6:0];
    assign rd       = if_instr[11:7];
    assign f3       = if_instr[14:12];
    assign rs1      = if_instr[19:15];
    assign rs2      = if_instr[24:20];
    assign imm_i    = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s    = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_u    = {if_instr[31:12], 12'b0};
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // Same-cycle writeback is forwarded so the operand never sees the stale entry.
    assign wb_hit  = wb_we && (wb_rd != 5'd0);
    assign rs1_val = (wb_hit && wb_rd == rs1) ? wb_data : ((rs1 == 5'd0) ? 32'd0 : rf_q[rs1]);
    assign rs2_val = (wb_hit && wb_rd == rs2) ? wb_data : ((rs2 == 5'd0) ? 32'd0 : rf_q[rs2]);

    assign if_ready = !ex_valid_q || ex_ready;
    assign accept   = if_valid && if_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wb_hit) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        dec        = '0;
        dec.opcode = opcode;
        case (opcode)
            OpReg: begin
                dec.a      = rs1_val;
                dec.b      = is_shift ? {27'b0, rs2_val[4:0]} : rs2_val;
                dec.funct3 = f3;
                dec.funct7 = if_instr[31:25];
                dec.rd     = rd;
                dec.reg_we = (rd != 5'd0);
            end
            OpImm: begin
                dec.a      = rs1_val;
                dec.b      = is_shift ? {27'b0, if_instr[24:20]} : imm_i;
                dec.funct3 = f3;
                dec.funct7 = (f3 == 3'b101) ? if_instr[31:25] : 7'd0;
                dec.rd     = rd;
                dec.reg_we = (rd != 5'd0);
            end
            OpLui: begin
                dec.b      = imm_u;
                dec.rd     = rd;
                dec.reg_we = (rd != 5'd0);
            end
            OpAuipc: begin
                dec.a      = if_pc;
                dec.b      = imm_u;
                dec.rd     = rd;
                dec.reg_we = (rd != 5'd0);
            end
            OpLoad: begin
                dec.a          = rs1_val;
                dec.b          = imm_i;
                dec.rd         = rd;
                dec.reg_we     = (rd != 5'd0);
                dec.mem_rd     = 1'b1;
                dec.mem_funct3 = f3;
            end
            OpStore: begin
                dec.a          = rs1_val;
                dec.b          = imm_s;
                dec.mem_wr     = 1'b1;
                dec.mem_funct3 = f3;
                dec.store_data = rs2_val;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Flush wins over accept; a stalled entry is held untouched.
    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            ex_d       = dec;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q       <= '0;
            ex_valid_q <= !RESET_PC_INVALID;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_a          = ex_q.a;
    assign ex_b          = ex_q.b;
    assign ex_funct3     = ex_q.funct3;
    assign ex_funct7     = ex_q.funct7;
    assign ex_opcode     = ex_q.opcode;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_we     = ex_q.reg_we;
    assign ex_mem_rd     = ex_q.mem_rd;
    assign ex_mem_wr     = ex_q.mem_wr;
    assign ex_mem_funct3 = ex_q.mem_funct3;
    assign ex_store_data = ex_q.store_data;
    assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed literal checks, then randomized traffic compared
// every cycle against a behavioural decode/handshake model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst, if_valid, if_ready, flush, wb_we, ex_valid, ex_ready;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [4:0]  wb_rd;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [2:0]  ex_funct3, ex_mem_funct3;
    logic [6:0]  ex_funct7, ex_opcode;
    logic [4:0]  ex_rd;
    logic        ex_reg_we, ex_mem_rd, ex_mem_wr, ex_illegal;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_a(ex_a), .ex_b(ex_b), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_mem_funct3(ex_mem_funct3),
        .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        mrd;
        logic        mwr;
        logic [2:0]  mf3;
        logic [31:0] sd;
        logic        ill;
    } exp_t;

    exp_t        act, m_out;
    logic        m_valid = 1'b0;
    logic        m_on = 1'b0;
    logic [31:0] m_rf [32];
    int          total = 0;
    int          bad = 0;

    assign act = {ex_a, ex_b, ex_funct3, ex_funct7, ex_opcode, ex_rd, ex_reg_we,
                  ex_mem_rd, ex_mem_wr, ex_mem_funct3, ex_store_data, ex_illegal};

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return 32'($signed(v));
    endfunction

    function automatic logic [31:0] rdval(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_we && wb_rd == r) return wb_data;
        return m_rf[r];
    endfunction

    function automatic exp_t decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic [31:0] v1, v2;
        logic [2:0]  fn;
        logic        shamt;
        e     = '0;
        v1    = rdval(ins[19:15]);
        v2    = rdval(ins[24:20]);
        fn    = ins[14:12];
        shamt = (fn == 3'd1) || (fn == 3'd5);
        e.op  = ins[6:0];
        e.rd  = ins[11:7];
        e.we  = (ins[11:7] != 5'd0);
        case (ins[6:0])
            7'h33: begin
                e.a = v1; e.f3 = fn; e.f7 = ins[31:25];
                e.b = shamt ? (v2 % 32) : v2;
            end
            7'h13: begin
                e.a  = v1; e.f3 = fn;
                e.b  = shamt ? 32'(ins[24:20]) : sext12(ins[31:20]);
                e.f7 = (fn == 3'd5) ? ins[31:25] : 7'd0;
            end
            7'h37: e.b = ins & 32'hFFFF_F000;
            7'h17: begin e.a = pc; e.b = ins & 32'hFFFF_F000; end
            7'h03: begin e.a = v1; e.b = sext12(ins[31:20]); e.mrd = 1'b1; e.mf3 = fn; end
            7'h23: begin
                e.a = v1; e.b = sext12({ins[31:25], ins[11:7]}); e.mwr = 1'b1;
                e.mf3 = fn; e.sd = v2; e.rd = 5'd0; e.we = 1'b0;
            end
            default: begin e.ill = 1'b1; e.rd = 5'd0; e.we = 1'b0; end
        endcase
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_on    <= 1'b1;
            m_valid <= 1'b0;
            m_out   <= '0;
            for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
        end else begin
            if (flush) m_valid <= 1'b0;
            else if (if_valid && (!m_valid || ex_ready)) begin
                m_valid <= 1'b1;
                m_out   <= decode(if_instr, if_pc);
            end else if (ex_ready) m_valid <= 1'b0;
            if (wb_we && wb_rd != 5'd0) m_rf[wb_rd] <= wb_data;
        end
    end

    task automatic model_cmp();
        if (m_on) begin
            total++;
            if (ex_valid !== m_valid) begin
                bad++;
                $display("FAIL model ex_valid: got=%b want=%b at %0t", ex_valid, m_valid, $time);
            end
            total++;
            if (if_ready !== (!m_valid || ex_ready)) begin
                bad++;
                $display("FAIL model if_ready: got=%b want=%b at %0t", if_ready,
                         !m_valid || ex_ready, $time);
            end
            if (m_valid) begin
                total++;
                if (act !== m_out) begin
                    bad++;
                    $display("FAIL model ex fields: got=%h want=%h at %0t", act, m_out, $time);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cmp();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic iv, input logic [31:0] ins, input logic we,
                       input logic [4:0] rd, input logic [31:0] d);
        if_valid = iv; if_instr = ins; wb_we = we; wb_rd = rd; wb_data = d;
        step();
        if_valid = 1'b0; wb_we = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [2:0]  s1, s2;
        r  = $urandom();
        s1 = 3'($urandom_range(0, 7));
        s2 = 3'($urandom_range(0, 7));
        r[19:15] = {2'b00, s1};
        r[24:20] = {2'b00, s2};
        case ($urandom_range(0, 6))
            0: r[6:0] = 7'h33;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h37;
            3: r[6:0] = 7'h17;
            4: r[6:0] = 7'h03;
            5: r[6:0] = 7'h23;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = 32'h1000; flush = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("reset ex_valid", 32'(ex_valid), 32'd0);
        chk("reset if_ready", 32'(if_ready), 32'd1);
        chk("reset ex_a", ex_a, 32'd0);
        chk("reset ex_b", ex_b, 32'd0);
        chk("reset ex_reg_we", 32'(ex_reg_we), 32'd0);

        cyc(1'b0, 32'h0, 1'b1, 5'd1, 32'd5);
        cyc(1'b1, 32'h00500093, 1'b0, 5'd0, 32'd0);
        chk("addi valid", 32'(ex_valid), 32'd1);
        chk("addi a", ex_a, 32'd0);
        chk("addi b", ex_b, 32'd5);
        chk("addi f3", 32'(ex_funct3), 32'd0);
        chk("addi f7", 32'(ex_funct7), 32'd0);
        chk("addi rd", 32'(ex_rd), 32'd1);
        chk("addi we", 32'(ex_reg_we), 32'd1);

        cyc(1'b0, 32'h0, 1'b1, 5'd1, 32'h8000_0000);
        cyc(1'b1, 32'h4020D193, 1'b0, 5'd0, 32'd0);
        chk("srai a", ex_a, 32'h8000_0000);
        chk("srai b", ex_b, 32'd2);
        chk("srai f3", 32'(ex_funct3), 32'd5);
        chk("srai f7", 32'(ex_funct7), 32'h20);

        cyc(1'b1, 32'h402082B3, 1'b1, 5'd2, 32'd7);
        chk("sub a", ex_a, 32'h8000_0000);
        chk("sub bypass b", ex_b, 32'd7);
        chk("sub f7", 32'(ex_funct7), 32'h20);
        chk("sub f3", 32'(ex_funct3), 32'd0);

        cyc(1'b0, 32'h0, 1'b1, 5'd1, 32'h100);
        cyc(1'b0, 32'h0, 1'b1, 5'd2, 32'hAB);
        cyc(1'b1, 32'hFE20AE23, 1'b0, 5'd0, 32'd0);
        chk("sw a", ex_a, 32'h100);
        chk("sw b", ex_b, 32'hFFFF_FFFC);
        chk("sw mem_wr", 32'(ex_mem_wr), 32'd1);
        chk("sw store_data", ex_store_data, 32'hAB);
        chk("sw mem_funct3", 32'(ex_mem_funct3), 32'd2);
        chk("sw reg_we", 32'(ex_reg_we), 32'd0);

        cyc(1'b1, 32'h123453B7, 1'b0, 5'd0, 32'd0);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h00500293, 1'b0, 5'd0, 32'd0);
            chk("stall if_ready", 32'(if_ready), 32'd0);
            chk("stall ex_b", ex_b, 32'h1234_5000);
            chk("stall ex_rd", 32'(ex_rd), 32'd7);
        end
        ex_ready = 1'b1;
        cyc(1'b1, 32'h00500293, 1'b0, 5'd0, 32'd0);
        chk("post-stall rd", 32'(ex_rd), 32'd5);
        chk("post-stall b", ex_b, 32'd5);

        flush = 1'b1;
        cyc(1'b1, 32'h00500093, 1'b0, 5'd0, 32'd0);
        flush = 1'b0;
        chk("flush ex_valid", 32'(ex_valid), 32'd0);

        cyc(1'b0, 32'h0, 1'b1, 5'd0, 32'hFFFF);
        cyc(1'b1, 32'h000002B3, 1'b1, 5'd0, 32'hFFFF);
        chk("x0 a", ex_a, 32'd0);
        chk("x0 b", ex_b, 32'd0);

        cyc(1'b1, 32'h00000073, 1'b0, 5'd0, 32'd0);
        chk("illegal flag", 32'(ex_illegal), 32'd1);
        chk("illegal we", 32'(ex_reg_we), 32'd0);
        chk("illegal opcode", 32'(ex_opcode), 32'h73);

        // Reset while stalled must drop the entry and clear the register file.
        ex_ready = 1'b0;
        cyc(1'b1, 32'h123453B7, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ex_ready = 1'b1;
        chk("rst-stall ex_valid", 32'(ex_valid), 32'd0);
        cyc(1'b1, 32'h00008293, 1'b0, 5'd0, 32'd0);
        chk("rst cleared x1", ex_a, 32'd0);

        for (int n = 0; n < 4000; n++) begin
            rst      = ($urandom_range(0, 499) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            wb_we    = ($urandom_range(0, 1) != 0);
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom();
            if_instr = rand_instr();
            if_pc    = $urandom();
            step();
        end
        rst = 1'b0; flush = 1'b0; if_valid = 1'b0; wb_we = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode/operand-fetch stage directly upstream of the single-cycle ALU.
- Decodes RV32I OP, OP-IMM, LUI, AUIPC, LOAD and STORE instructions.
- Owns the 32x32 integer register file and generates immediates.
- Drives the ALU operand and control inputs (a, b, funct3, funct7, opcode) from a registered ID/EX output stage with a valid/ready handshake, flush and writeback bypass.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC_INVALID, 1, when 1 the output register resets to a bubble (ex_valid=0).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- if_valid  input  1  instruction/pc from fetch are valid.
- if_ready  output  1  stage can accept an instruction this cycle.
- if_instr  input  32  raw instruction word.
- if_pc  input  32  pc of if_instr.
- flush  input  1  kill the held instruction and drop the incoming one.
- wb_we  input  1  writeback register write enable.
- wb_rd  input  5  writeback destination register.
- wb_data  input  32  writeback data.
- ex_valid  output  1  ID/EX register holds a live instruction.
- ex_ready  input  1  downstream (ALU/EX) consumes this cycle.
- ex_a  output  32  ALU operand a.
- ex_b  output  32  ALU operand b.
- ex_funct3  output  3  ALU funct3.
- ex_funct7  output  7  ALU funct7.
- ex_opcode  output  7  instruction opcode, passed through.
- ex_rd  output  5  destination register.
- ex_reg_we  output  1  instruction writes rd (forced 0 when rd=0).
- ex_mem_rd  output  1  load.
- ex_mem_wr  output  1  store.
- ex_mem_funct3  output  3  original funct3 for load/store width.
- ex_store_data  output  32  rs2 value for stores.
- ex_illegal  output  1  opcode not in the supported set.

Behaviour:
- Reset:
  - All ex_* outputs are 0 and ex_valid=0.
  - All register file entries are cleared to 0.
  - if_ready=1 in the cycle after reset deasserts.
- Handshake and pipeline register:
  - if_ready = !ex_valid || ex_ready. The signal is combinational and independent of if_valid.
  - Accept occurs when if_valid && if_ready. On accept the output register loads the decoded fields and ex_valid=1 on the next edge. Latency is 1 cycle from accept to ex_valid.
  - ex_ready && !accept sets ex_valid to 0 next cycle.
  - ex_valid && !ex_ready holds all ex_* stable. No change is permitted while stalled.
  - flush has priority over accept: ex_valid=0 next cycle and the incoming instruction is discarded. Other ex_* fields may retain stale values.
  - rst has priority over everything, including mid-stall.
- Register file:
  - Two combinational read ports and one write port. A write occurs on the clock edge when wb_we && wb_rd!=0.
  - x0 always reads 0, and writes to x0 are ignored.
  - Bypass: if wb_we && wb_rd!=0 && wb_rd matches rs1/rs2 in the accept cycle, the operand uses wb_data.
  - Operands are captured at accept only. RAW hazards against in-flight instructions are handled by a separate hazard unit, not this block.
- Immediates:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - U: {instr[31:12], 12'b0}.
- Operand mapping:
  - OP (0110011): a=rs1, b=rs2, funct3/funct7 passed through. Shifts (funct3=001/101) force b={27'b0, rs2[4:0]}.
  - OP-IMM (0010011): a=rs1, b=I-imm, funct7=0. Exception: funct3=101 passes funct7=instr[31:25] (SRAI/SRLI). Shifts (001/101) use b={27'b0, instr[24:20]}.
  - LUI (0110111): a=0, b=U-imm, funct3=000, funct7=0.
  - AUIPC (0010111): a=pc, b=U-imm, funct3=000, funct7=0.
  - LOAD (0000011): a=rs1, b=I-imm, funct3=000, funct7=0, mem_rd=1, reg_we=1.
  - STORE (0100011): a=rs1, b=S-imm, funct3=000, funct7=0, mem_wr=1, reg_we=0, store_data=rs2.
  - Any other opcode: ex_illegal=1, reg_we=0, mem_rd=0, mem_wr=0, a=b=0, funct3=funct7=0. The instruction still flows through the handshake.
- ex_reg_we=1 for OP, OP-IMM, LUI, AUIPC and LOAD when rd!=0.

Test Plan:
- After rst, write x1=5 via WB; accept 0x00500093 (ADDI x1,x0,5) -> next cycle ex_valid=1, ex_a=0, ex_b=5, ex_funct3=000, ex_funct7=0, ex_rd=1, ex_reg_we=1.
- x1=0x80000000; accept 0x4020D193 (SRAI x3,x1,2) -> ex_a=0x80000000, ex_b=2, ex_funct3=101, ex_funct7=0100000.
- Same cycle as accept of 0x402082B3 (SUB x5,x1,x2), WB writes x2=7 -> ex_b=7 (bypass), ex_funct7=0100000, ex_funct3=000.
- Accept 0xFE20AE23 (SW x2,-4(x1)) with x1=0x100, x2=0xAB -> ex_a=0x100, ex_b=0xFFFFFFFC, ex_mem_wr=1, ex_store_data=0xAB, ex_mem_funct3=010, ex_reg_we=0.
- Accept 0x123453B7 (LUI x7), hold ex_ready=0 for 3 cycles while if_valid=1 -> if_ready=0 and ex_* stable with ex_b=0x12345000; when ex_ready=1, the next instruction is accepted.
- flush asserted with if_valid=1 and ex_valid=1 -> ex_valid=0 next cycle. WB write to x0 with 0xFFFF -> x0 still reads 0. Opcode 1110011 -> ex_illegal=1.
